// File: rtl/dev_tx_sched_if.sv
// rtl/dev_tx_sched_if.sv - handshake and TX bus bundle for dev_tx_sched
// Signals: link_up, prim_req/prim_data/prim_k/prim_gnt, frm_req/frm_data/frm_k/frm_gnt,
//          dev_tx_data/dev_tx_charisk/align_active.
// Modports: master = requester/PHY side (drives requests), slave = scheduler.
interface dev_tx_sched_if;
    logic        link_up;
    logic        prim_req;
    logic [31:0] prim_data;
    logic        prim_k;
    logic        prim_gnt;
    logic        frm_req;
    logic [31:0] frm_data;
    logic        frm_k;
    logic        frm_gnt;
    logic [31:0] dev_tx_data;
    logic        dev_tx_charisk;
    logic        align_active;

    modport master (
        output link_up, prim_req, prim_data, prim_k, frm_req, frm_data, frm_k,
        input  prim_gnt, frm_gnt, dev_tx_data, dev_tx_charisk, align_active
    );

    modport slave (
        input  link_up, prim_req, prim_data, prim_k, frm_req, frm_data, frm_k,
        output prim_gnt, frm_gnt, dev_tx_data, dev_tx_charisk, align_active
    );
endinterface

// File: rtl/dev_tx_sched.sv
// rtl/dev_tx_sched.sv - device TX dword scheduler with periodic ALIGN insertion
// Ports: clk, rst (async active-high), bus (dev_tx_sched_if.slave):
//   link_up in; prim_req/prim_data/prim_k in, prim_gnt out;
//   frm_req/frm_data/frm_k in, frm_gnt out; dev_tx_data/dev_tx_charisk/align_active out (registered).
// Parameters: ALIGN_PERIOD (4..1024) dwords between ALIGN bursts, ALIGN_BURST (1..4) ALIGNs per burst.
// Macro DEV_TX_SCHED_ALIGN_EN: when defined, periodic ALIGN bursts are inserted in RUN;
// when undefined, the ALIGN state and dword counter do not exist.
module dev_tx_sched #(
    parameter int ALIGN_PERIOD = 256,
    parameter int ALIGN_BURST  = 2
) (
    input logic           clk,
    input logic           rst,
    dev_tx_sched_if.slave bus
);
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;

    typedef enum logic [1:0] {LINKDOWN, RUN, ALIGN} state_t;

    state_t      state, state_nxt;
    logic [31:0] tx_data_q, tx_data_nxt;
    logic        tx_k_q, tx_k_nxt;
    logic        align_q, align_nxt;
    logic        prim_gnt, frm_gnt;

    if (ALIGN_PERIOD < 4 || ALIGN_PERIOD > 1024 || ALIGN_BURST < 1 || ALIGN_BURST > 4) begin : g_param_check
        $error("dev_tx_sched: ALIGN_PERIOD or ALIGN_BURST out of range");
    end

`ifdef DEV_TX_SCHED_ALIGN_EN
    localparam logic [10:0] PERIOD_LAST = 11'(ALIGN_PERIOD - 1);
    localparam logic [10:0] BURST_LAST  = 11'(ALIGN_BURST - 1);

    // Counts issued dwords in RUN, and burst position while in ALIGN.
    logic [10:0] cnt, cnt_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LINKDOWN;
`ifdef DEV_TX_SCHED_ALIGN_EN
            cnt       <= '0;
`endif
            tx_data_q <= ALIGN_DW;
            tx_k_q    <= 1'b1;
            align_q   <= 1'b1;
        end else begin
            state     <= state_nxt;
`ifdef DEV_TX_SCHED_ALIGN_EN
            cnt       <= cnt_nxt;
`endif
            tx_data_q <= tx_data_nxt;
            tx_k_q    <= tx_k_nxt;
            align_q   <= align_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
`ifdef DEV_TX_SCHED_ALIGN_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            LINKDOWN: begin
                if (bus.link_up) begin
                    state_nxt = RUN;
`ifdef DEV_TX_SCHED_ALIGN_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            RUN: begin
                if (!bus.link_up) begin
                    state_nxt = LINKDOWN;
                end
`ifdef DEV_TX_SCHED_ALIGN_EN
                // Every RUN cycle issues a dword (grant or SYNC fill).
                else if (cnt == PERIOD_LAST) begin
                    state_nxt = ALIGN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
`endif
            end
`ifdef DEV_TX_SCHED_ALIGN_EN
            ALIGN: begin
                if (!bus.link_up) begin
                    state_nxt = LINKDOWN;
                end else if (cnt == BURST_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
`endif
            default: state_nxt = LINKDOWN;
        endcase
    end

    // Grants and the dword to register this cycle; anything other than an
    // active RUN cycle (LINKDOWN, ALIGN, link loss) loads an ALIGN dword.
    always_comb begin
        prim_gnt    = (state == RUN) && bus.link_up && bus.prim_req;
        frm_gnt     = (state == RUN) && bus.link_up && bus.frm_req && !bus.prim_req;
        tx_data_nxt = ALIGN_DW;
        tx_k_nxt    = 1'b1;
        align_nxt   = 1'b1;
        if (prim_gnt) begin
            tx_data_nxt = bus.prim_data;
            tx_k_nxt    = bus.prim_k;
            align_nxt   = 1'b0;
        end else if (frm_gnt) begin
            tx_data_nxt = bus.frm_data;
            tx_k_nxt    = bus.frm_k;
            align_nxt   = 1'b0;
        end else if ((state == RUN) && bus.link_up) begin
            tx_data_nxt = SYNC_DW;
            tx_k_nxt    = 1'b1;
            align_nxt   = 1'b0;
        end
    end

    assign bus.prim_gnt       = prim_gnt;
    assign bus.frm_gnt        = frm_gnt;
    assign bus.dev_tx_data    = tx_data_q;
    assign bus.dev_tx_charisk = tx_k_q;
    assign bus.align_active   = align_q;
endmodule

// File: tb/tb_dev_tx_sched.sv
// tb/tb_dev_tx_sched.sv - scoreboard testbench for dev_tx_sched
module tb_dev_tx_sched;
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {int cyc; logic pg; logic fg;} gexp_t;
    typedef struct {int cyc; logic [31:0] d; logic k; logic a;} oexp_t;
    gexp_t gq[$];
    oexp_t oq[$];
    gexp_t ge;
    oexp_t oe;

    dev_tx_sched_if bus();

    dev_tx_sched #(.ALIGN_PERIOD(256), .ALIGN_BURST(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (gq.size() > 0 && gq[0].cyc <= cyc) begin
            ge = gq.pop_front();
            checks++;
            if (bus.prim_gnt !== ge.pg || bus.frm_gnt !== ge.fg) begin
                failures++;
                $display("FAIL grant cyc=%0d got prim=%b frm=%b want prim=%b frm=%b",
                         cyc, bus.prim_gnt, bus.frm_gnt, ge.pg, ge.fg);
            end
        end
        while (oq.size() > 0 && oq[0].cyc <= cyc) begin
            oe = oq.pop_front();
            checks++;
            if (bus.dev_tx_data !== oe.d || bus.dev_tx_charisk !== oe.k || bus.align_active !== oe.a) begin
                failures++;
                $display("FAIL txout cyc=%0d got %h/%b/%b want %h/%b/%b", cyc,
                         bus.dev_tx_data, bus.dev_tx_charisk, bus.align_active, oe.d, oe.k, oe.a);
            end
        end
    end

    task automatic push_g(input int c, input logic pg, input logic fg);
        gexp_t e;
        e.cyc = c; e.pg = pg; e.fg = fg;
        gq.push_back(e);
    endtask

    task automatic push_o(input int c, input logic [31:0] d, input logic k, input logic a);
        oexp_t e;
        e.cyc = c; e.d = d; e.k = k; e.a = a;
        oq.push_back(e);
    endtask

    // Called just after a rising edge: drives this cycle's inputs, expects the
    // grants now and the registered dword after the next edge.
    task automatic step(input logic lu, input logic pr, input logic [31:0] pd, input logic pk,
                        input logic fr, input logic [31:0] fd,
                        input logic epg, input logic efg,
                        input logic [31:0] ed, input logic ek, input logic ea, input logic chk_out);
        bus.link_up   = lu;
        bus.prim_req  = pr;
        bus.prim_data = pd;
        bus.prim_k    = pk;
        bus.frm_req   = fr;
        bus.frm_data  = fd;
        push_g(cyc, epg, efg);
        if (chk_out) push_o(cyc + 1, ed, ek, ea);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_sync(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, SYNC_DW, 1, 0, 1);
    endtask

    task automatic burst_align(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, ALIGN_DW, 1, 1, 1);
    endtask

    initial begin
        int seq;
        bus.link_up = 0; bus.prim_req = 0; bus.prim_data = 0; bus.prim_k = 0;
        bus.frm_req = 0; bus.frm_data = 0; bus.frm_k = 0;

        // reset state
        repeat (3) begin
            @(posedge clk);
            #1;
            push_g(cyc, 0, 0);
            push_o(cyc, ALIGN_DW, 1, 1);
        end
        rst = 0;

        // link down: ALIGN every cycle, grants low even with requests
        for (int i = 0; i < 10; i++)
            step(0, i[0], 32'h11110000, 0, 1, 32'h22220000, 0, 0, ALIGN_DW, 1, 1, 1);

        // relink cycle still emits ALIGN
        step(1, 0, 0, 0, 0, 0, 0, 0, ALIGN_DW, 1, 1, 1);

`ifdef DEV_TX_SCHED_ALIGN_EN
        idle_sync(256);
        burst_align(2);
        idle_sync(4);
`else
        for (int i = 0; i < 1000; i++)
            step(1, 0, 0, 0, 1, i, 0, 1, i, 0, 0, 1);
`endif

        // priority, pending frame, K passthrough, withdrawn request
        step(1, 1, 32'h12345678, 0, 1, 32'hA5A50001, 1, 0, 32'h12345678, 0, 0, 1);
        step(1, 0, 0, 0, 1, 32'hA5A50001, 0, 1, 32'hA5A50001, 0, 0, 1);
        step(1, 1, 32'h000000BC, 1, 0, 0, 1, 0, 32'h000000BC, 1, 0, 1);
        step(1, 1, 32'h22222222, 0, 1, 32'h33333333, 1, 0, 32'h22222222, 0, 0, 1);
        step(1, 0, 0, 0, 0, 32'h33333333, 0, 0, SYNC_DW, 1, 0, 1);

`ifdef DEV_TX_SCHED_ALIGN_EN
        // frame held across two period boundaries; 9 dwords already issued this period
        seq = 0;
        for (int j = 0; j < 516; j++) begin
            if (j == 247 || j == 248 || j == 505 || j == 506) begin
                step(1, 0, 0, 0, 1, seq, 0, 0, ALIGN_DW, 1, 1, 1);
            end else begin
                step(1, 0, 0, 0, 1, seq, 0, 1, seq, 0, 0, 1);
                seq++;
            end
        end

        // drop link on first ALIGN burst cycle, relink restarts the period
        idle_sync(247);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, ALIGN_DW, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, ALIGN_DW, 1, 1, 1);
        idle_sync(256);
        burst_align(2);
        idle_sync(2);
`endif

        // link loss in RUN with both requests pending
        step(0, 1, 32'h44444444, 0, 1, 32'h55555555, 0, 0, ALIGN_DW, 1, 1, 1);
        step(1, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, ALIGN_DW, 1, 1, 1);
        step(1, 0, 0, 0, 1, 32'hCAFE0001, 0, 1, 32'hCAFE0001, 0, 0, 0);

        // asynchronous reset between edges, with a frame request still held
        rst = 1;
        #1;
        push_g(cyc, 0, 0);
        push_o(cyc, ALIGN_DW, 1, 1);
        @(posedge clk);
        #1;
        push_g(cyc, 0, 0);
        push_o(cyc, ALIGN_DW, 1, 1);
        @(posedge clk);
        #1;
        rst = 0;
        step(1, 0, 0, 0, 1, 32'hCAFE0002, 0, 0, ALIGN_DW, 1, 1, 1);
        step(1, 0, 0, 0, 1, 32'hCAFE0002, 0, 1, 32'hCAFE0002, 0, 0, 1);
        idle_sync(2);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gq.size() != 0 || oq.size() != 0) begin
            failures++;
            $display("FAIL drain got grant_q=%0d out_q=%0d want 0/0", gq.size(), oq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dev_tx_sched.md
DEV_TX_SCHED -- requirements
Module: dev_tx_sched

Interface
REQ-001 SHALL have parameter ALIGN_PERIOD, default 256: non-ALIGN dwords sent between ALIGN bursts (legal range 4..1024).
REQ-002 SHALL have parameter ALIGN_BURST, default 2: consecutive ALIGN dwords per burst (legal range 1..4).
REQ-003 SHALL have a single clock and an asynchronous active-high reset, ports named clk and rst.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  device-side 75 MHz dword clock
- rst  in  1  asynchronous active-high reset
- link_up  in  1  PHY link ready
- prim_req  in  1  primitive source requests a slot
- prim_data  in  32  primitive dword
- prim_k  in  1  primitive charisk (byte 0)
- prim_gnt  out  1  primitive dword accepted this cycle
- frm_req  in  1  frame source requests a slot
- frm_data  in  32  frame dword
- frm_k  in  1  frame charisk
- frm_gnt  out  1  frame dword accepted this cycle
- dev_tx_data  out  32  registered TX dword to PHY interface
- dev_tx_charisk  out  1  registered TX charisk
- align_active  out  1  registered; high while an ALIGN dword is on dev_tx_data

Function
REQ-005 SHALL implement states LINKDOWN, RUN and ALIGN.
REQ-006 LINKDOWN: output ALIGN (0x7B4A4ABC, charisk 1) every cycle; both grants low.
REQ-007 LINKDOWN->RUN SHALL occur on the first cycle link_up is sampled high; the ALIGN counter clears to 0.
REQ-008 RUN or ALIGN SHALL go to LINKDOWN on any cycle link_up is low, abandoning any burst in progress; grants are low that cycle.
REQ-009 RUN: grant priority prim > frm; at most one grant per cycle; a grant is combinational from req, state and counter.
REQ-010 A granted dword SHALL appear on dev_tx_data/dev_tx_charisk exactly one cycle after the grant cycle (latency 1).
REQ-011 RUN with no request: output SYNC (0xB5B5957C, charisk 1).
REQ-012 Each dword issued in RUN (granted or SYNC fill) SHALL increment the 11-bit counter.
REQ-013 When the counter equals ALIGN_PERIOD-1 and a dword issues, the next state SHALL be ALIGN and the counter SHALL clear.
REQ-014 ALIGN: emit ALIGN_BURST ALIGN dwords on consecutive cycles with both grants low, then return to RUN.
REQ-015 Simultaneous prim_req and frm_req SHALL grant prim only; frm_req stays pending, and the requester holds data until granted.
REQ-016 A requester whose req is deasserted before its grant loses nothing; no dword is emitted for it.
REQ-017 align_active SHALL equal 1 exactly when the registered output is an ALIGN dword.

Reset
REQ-018 While rst is high: state LINKDOWN, counter 0, dev_tx_data 0x7B4A4ABC, dev_tx_charisk 1, align_active 1, grants 0.
REQ-019 Reset assertion SHALL take effect immediately and asynchronously; deassertion SHALL be sampled synchronously on clk.
REQ-020 Reset mid-burst or mid-frame SHALL discard all pending state; requesters re-arbitrate from LINKDOWN.

Configuration
REQ-021 Macro DEV_TX_SCHED_ALIGN_EN defined: periodic ALIGN insertion per REQ-013/014.
REQ-022 Macro DEV_TX_SCHED_ALIGN_EN undefined: ALIGN state and counter are removed, RUN never leaves except to LINKDOWN, and LINKDOWN behaviour is unchanged.

Verification
REQ-023 Reset, then link_up=0 for 10 cycles -> ten ALIGN dwords, charisk 1, prim_gnt=frm_gnt=0.
REQ-024 link_up=1, no requests, ALIGN_PERIOD=256 -> 256 SYNC dwords, then exactly 2 ALIGN dwords, then SYNC resumes; align_active high only for those 2 cycles.
REQ-025 prim_req and frm_req both high with prim_data=0x12345678 -> prim_gnt only; next cycle output 0x12345678; frm granted on the first cycle prim_req drops.
REQ-026 frm_req held continuously across a period boundary -> frm_gnt low for exactly 2 cycles while ALIGN is output, and no frame dword is lost or duplicated (sequence check 0..511).
REQ-027 link_up dropped during ALIGN burst cycle 1 -> next output ALIGN in LINKDOWN; on relink, counter restarts and the first ALIGN burst comes after 256 dwords.
REQ-028 Build without DEV_TX_SCHED_ALIGN_EN, 1000 RUN cycles of frame traffic -> no ALIGN output and frm_gnt high every cycle.
